// File: rtl/mem_stage_if.sv
// Dcache request/response bus between the MEM stage and the data cache.
// master: req/we/addr/wdata/wstrb out, ready/rdata in; slave: the reverse.
interface mem_stage_if;
    logic        mem_dcache_req_o;
    logic        mem_dcache_we_o;
    logic [31:0] mem_dcache_addr_o;
    logic [31:0] mem_dcache_wdata_o;
    logic [3:0]  mem_dcache_wstrb_o;
    logic        dcache_ready_i;
    logic [31:0] dcache_rdata_i;

    modport master (
        output mem_dcache_req_o,
        output mem_dcache_we_o,
        output mem_dcache_addr_o,
        output mem_dcache_wdata_o,
        output mem_dcache_wstrb_o,
        input  dcache_ready_i,
        input  dcache_rdata_i
    );

    modport slave (
        input  mem_dcache_req_o,
        input  mem_dcache_we_o,
        input  mem_dcache_addr_o,
        input  mem_dcache_wdata_o,
        input  mem_dcache_wstrb_o,
        output dcache_ready_i,
        output dcache_rdata_i
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: issues loads/stores to the Dcache (IDLE/WAIT FSM), aligns
// load data, and registers the result bundle to WB.
// Ports: clk, rst_n (async low); ex_* from EX; dc (mem_stage_if.master);
// mem_stall_o to flow control; mem_valid_o + mem_reg_* / mem_csr_* to WB.
// Optional macro MEM_MISALIGN_CHECK_EN adds mem_misalign_o and traps
// misaligned half/word accesses instead of issuing them.
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ex_reg_wdata_i,
    input  logic [4:0]  ex_reg_waddr_i,
    input  logic        ex_reg_we_i,
    input  logic [31:0] ex_csr_wdata_i,
    input  logic [11:0] ex_csr_waddr_i,
    input  logic        ex_csr_we_i,
    input  logic        ex_mtype_i,
    input  logic        ex_mem_rw_i,
    input  logic [1:0]  ex_mem_width_i,
    input  logic        ex_mem_rdtype_i,
    input  logic [31:0] ex_mem_addr_i,
    input  logic [31:0] ex_mem_wr_data_i,
    mem_stage_if.master dc,
    output logic        mem_stall_o,
    output logic        mem_valid_o,
    output logic [31:0] mem_reg_wdata_o,
    output logic [4:0]  mem_reg_waddr_o,
    output logic        mem_reg_we_o,
    output logic [31:0] mem_csr_wdata_o,
    output logic [11:0] mem_csr_waddr_o,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic        mem_csr_we_o,
    output logic        mem_misalign_o
`else
    output logic        mem_csr_we_o
`endif
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state;

    logic [31:0] hold_reg_wdata;
    logic [4:0]  hold_reg_waddr;
    logic        hold_reg_we;
    logic [31:0] hold_csr_wdata;
    logic [11:0] hold_csr_waddr;
    logic        hold_csr_we;
    logic        hold_rw;
    logic [1:0]  hold_width;
    logic        hold_rdtype;
    logic [31:0] hold_addr;
    logic [31:0] hold_wr_data;

    logic [31:0] cur_reg_wdata;
    logic [4:0]  cur_reg_waddr;
    logic        cur_reg_we;
    logic [31:0] cur_csr_wdata;
    logic [11:0] cur_csr_waddr;
    logic        cur_csr_we;
    logic        cur_mtype;
    logic        cur_rw;
    logic [1:0]  cur_width;
    logic        cur_rdtype;
    logic [31:0] cur_addr;
    logic [31:0] cur_wr_data;

    logic        misal;
    logic        req;
    logic        stall;
    logic [31:0] lane;
    logic [31:0] load_data;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic [31:0] wb_reg_wdata;
    logic        wb_reg_we;

    // In WAIT the request is replayed from the holding registers so the
    // Dcache sees a stable request whatever EX presents meanwhile.
    always_comb begin
        cur_reg_wdata = ex_reg_wdata_i;
        cur_reg_waddr = ex_reg_waddr_i;
        cur_reg_we    = ex_reg_we_i;
        cur_csr_wdata = ex_csr_wdata_i;
        cur_csr_waddr = ex_csr_waddr_i;
        cur_csr_we    = ex_csr_we_i;
        cur_mtype     = ex_mtype_i;
        cur_rw        = ex_mem_rw_i;
        cur_width     = ex_mem_width_i;
        cur_rdtype    = ex_mem_rdtype_i;
        cur_addr      = ex_mem_addr_i;
        cur_wr_data   = ex_mem_wr_data_i;
        if (state == WAIT) begin
            cur_reg_wdata = hold_reg_wdata;
            cur_reg_waddr = hold_reg_waddr;
            cur_reg_we    = hold_reg_we;
            cur_csr_wdata = hold_csr_wdata;
            cur_csr_waddr = hold_csr_waddr;
            cur_csr_we    = hold_csr_we;
            cur_mtype     = 1'b1;
            cur_rw        = hold_rw;
            cur_width     = hold_width;
            cur_rdtype    = hold_rdtype;
            cur_addr      = hold_addr;
            cur_wr_data   = hold_wr_data;
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    assign misal = cur_mtype &&
                   ((cur_width == 2'b01 && cur_addr[0]) ||
                    (cur_width[1] && cur_addr[1:0] != 2'b00));
`else
    assign misal = 1'b0;
`endif

    // Gated by rst_n so req/stall drop the instant reset asserts.
    assign req   = rst_n && cur_mtype && !misal;
    assign stall = req && !dc.dcache_ready_i;

    // Width 11 falls into the word branch via cur_width[1].
    always_comb begin
        lane      = dc.dcache_rdata_i >> {cur_addr[1:0], 3'b000};
        load_data = dc.dcache_rdata_i;
        st_data   = cur_wr_data;
        st_strb   = 4'b1111;
        unique case (1'b1)
            (cur_width == 2'b00): begin
                load_data = cur_rdtype ? {24'b0, lane[7:0]}
                                       : {{24{lane[7]}}, lane[7:0]};
                st_data   = {4{cur_wr_data[7:0]}};
                st_strb   = 4'b0001 << cur_addr[1:0];
            end
            (cur_width == 2'b01): begin
                lane      = cur_addr[1] ? {16'b0, dc.dcache_rdata_i[31:16]}
                                        : {16'b0, dc.dcache_rdata_i[15:0]};
                load_data = cur_rdtype ? {16'b0, lane[15:0]}
                                       : {{16{lane[15]}}, lane[15:0]};
                st_data   = {2{cur_wr_data[15:0]}};
                st_strb   = cur_addr[1] ? 4'b1100 : 4'b0011;
            end
            cur_width[1]: begin
                load_data = dc.dcache_rdata_i;
            end
        endcase
    end

    assign dc.mem_dcache_req_o   = req;
    assign dc.mem_dcache_we_o    = cur_rw;
    assign dc.mem_dcache_addr_o  = {cur_addr[31:2], 2'b00};
    assign dc.mem_dcache_wdata_o = st_data;
    assign dc.mem_dcache_wstrb_o = st_strb;
    assign mem_stall_o           = stall;

    assign wb_reg_wdata = (cur_mtype && !cur_rw && !misal) ? load_data
                                                           : cur_reg_wdata;
    assign wb_reg_we    = cur_reg_we && !(cur_mtype && (cur_rw || misal));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            hold_reg_wdata  <= '0;
            hold_reg_waddr  <= '0;
            hold_reg_we     <= 1'b0;
            hold_csr_wdata  <= '0;
            hold_csr_waddr  <= '0;
            hold_csr_we     <= 1'b0;
            hold_rw         <= 1'b0;
            hold_width      <= '0;
            hold_rdtype     <= 1'b0;
            hold_addr       <= '0;
            hold_wr_data    <= '0;
            mem_valid_o     <= 1'b0;
            mem_reg_wdata_o <= '0;
            mem_reg_waddr_o <= '0;
            mem_reg_we_o    <= 1'b0;
            mem_csr_wdata_o <= '0;
            mem_csr_waddr_o <= '0;
            mem_csr_we_o    <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            mem_misalign_o  <= 1'b0;
`endif
        end else if (stall) begin
            mem_valid_o <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            mem_misalign_o <= 1'b0;
`endif
            if (state == IDLE) begin
                state          <= WAIT;
                hold_reg_wdata <= ex_reg_wdata_i;
                hold_reg_waddr <= ex_reg_waddr_i;
                hold_reg_we    <= ex_reg_we_i;
                hold_csr_wdata <= ex_csr_wdata_i;
                hold_csr_waddr <= ex_csr_waddr_i;
                hold_csr_we    <= ex_csr_we_i;
                hold_rw        <= ex_mem_rw_i;
                hold_width     <= ex_mem_width_i;
                hold_rdtype    <= ex_mem_rdtype_i;
                hold_addr      <= ex_mem_addr_i;
                hold_wr_data   <= ex_mem_wr_data_i;
            end
        end else begin
            state           <= IDLE;
            mem_valid_o     <= 1'b1;
            mem_reg_wdata_o <= wb_reg_wdata;
            mem_reg_waddr_o <= cur_reg_waddr;
            mem_reg_we_o    <= wb_reg_we;
            mem_csr_wdata_o <= cur_csr_wdata;
            mem_csr_waddr_o <= cur_csr_waddr;
            mem_csr_we_o    <= cur_csr_we;
`ifdef MEM_MISALIGN_CHECK_EN
            mem_misalign_o  <= misal;
`endif
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a random
// back-to-back stream; WB results are checked against a scoreboard queue.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] ex_reg_wdata;
    logic [4:0]  ex_reg_waddr;
    logic        ex_reg_we;
    logic [31:0] ex_csr_wdata;
    logic [11:0] ex_csr_waddr;
    logic        ex_csr_we;
    logic        ex_mtype;
    logic        ex_mem_rw;
    logic [1:0]  ex_mem_width;
    logic        ex_mem_rdtype;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_mem_wr_data;
    logic        mem_stall;
    logic        mem_valid;
    logic [31:0] mem_reg_wdata;
    logic [4:0]  mem_reg_waddr;
    logic        mem_reg_we;
    logic [31:0] mem_csr_wdata;
    logic [11:0] mem_csr_waddr;
    logic        mem_csr_we;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        mem_misalign;
`endif

    mem_stage_if dif ();

    mem_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_reg_wdata_i   (ex_reg_wdata),
        .ex_reg_waddr_i   (ex_reg_waddr),
        .ex_reg_we_i      (ex_reg_we),
        .ex_csr_wdata_i   (ex_csr_wdata),
        .ex_csr_waddr_i   (ex_csr_waddr),
        .ex_csr_we_i      (ex_csr_we),
        .ex_mtype_i       (ex_mtype),
        .ex_mem_rw_i      (ex_mem_rw),
        .ex_mem_width_i   (ex_mem_width),
        .ex_mem_rdtype_i  (ex_mem_rdtype),
        .ex_mem_addr_i    (ex_mem_addr),
        .ex_mem_wr_data_i (ex_mem_wr_data),
        .dc               (dif.master),
        .mem_stall_o      (mem_stall),
        .mem_valid_o      (mem_valid),
        .mem_reg_wdata_o  (mem_reg_wdata),
        .mem_reg_waddr_o  (mem_reg_waddr),
        .mem_reg_we_o     (mem_reg_we),
        .mem_csr_wdata_o  (mem_csr_wdata),
        .mem_csr_waddr_o  (mem_csr_waddr),
`ifdef MEM_MISALIGN_CHECK_EN
        .mem_csr_we_o     (mem_csr_we),
        .mem_misalign_o   (mem_misalign)
`else
        .mem_csr_we_o     (mem_csr_we)
`endif
    );

    typedef struct {
        logic [31:0] rw;
        logic [4:0]  ra;
        logic        re;
        logic [31:0] cw;
        logic [11:0] ca;
        logic        ce;
        logic        mis;
    } wb_t;

    wb_t exp_q[$];
    wb_t e;
    int  checks = 0;
    int  errors = 0;
    int  valid_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [31:0] model_load(
        input logic [1:0] w, input logic rdt,
        input logic [31:0] a, input logic [31:0] rd);
        logic [7:0]  b [4];
        logic [31:0] v;
        int          base;
        for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
        if (w == 2'b00) begin
            v = {24'b0, b[a[1:0]]};
            if (!rdt && v[7]) v[31:8] = '1;
        end else if (w == 2'b01) begin
            base = a[1] ? 2 : 0;
            v = {16'b0, b[base+1], b[base]};
            if (!rdt && v[15]) v[31:16] = '1;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic void model_store(
        input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
        output logic [3:0] s, output logic [31:0] o);
        int size;
        int base;
        size = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
        base = (int'(a[1:0]) / size) * size;
        for (int i = 0; i < 4; i++) begin
            s[i] = (i >= base) && (i < base + size);
            o[8*i +: 8] = d[8*(i % size) +: 8];
        end
    endfunction

    // Drive one EX bundle; optionally push its expected WB result.
    task automatic present(
        input bit push, input logic mt, input logic rw,
        input logic [1:0] w, input logic rdt,
        input logic [31:0] a, input logic [31:0] sd,
        input logic [31:0] rwd, input logic [31:0] rd,
        input logic [4:0] ra, input logic re);
        wb_t x;
        logic mis;
        ex_mtype       = mt;
        ex_mem_rw      = rw;
        ex_mem_width   = w;
        ex_mem_rdtype  = rdt;
        ex_mem_addr    = a;
        ex_mem_wr_data = sd;
        ex_reg_wdata   = rwd;
        ex_reg_waddr   = ra;
        ex_reg_we      = re;
        ex_csr_wdata   = rwd ^ 32'hA5A5_0F0F;
        ex_csr_waddr   = 12'h300 + {7'b0, ra};
        ex_csr_we      = ra[0];
        dif.dcache_rdata_i = rd;
`ifdef MEM_MISALIGN_CHECK_EN
        mis = mt && ((w == 2'b01 && a[0]) || (w[1] && a[1:0] != 2'b00));
`else
        mis = 1'b0;
`endif
        if (push) begin
            x.rw  = (mt && !rw && !mis) ? model_load(w, rdt, a, rd) : rwd;
            x.ra  = ra;
            x.re  = re && !(mt && (rw || mis));
            x.cw  = rwd ^ 32'hA5A5_0F0F;
            x.ca  = 12'h300 + {7'b0, ra};
            x.ce  = ra[0];
            x.mis = mis;
            exp_q.push_back(x);
        end
    endtask

    task automatic bubble();
        present(0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 5'd0, 0);
    endtask

    // Scoreboard consumer: each valid WB cycle retires one expectation.
    always @(posedge clk) begin
        #1;
        if (rst_n && mem_valid) begin
            valid_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (mem_reg_wdata !== e.rw || mem_reg_waddr !== e.ra ||
                    mem_reg_we !== e.re || mem_csr_wdata !== e.cw ||
                    mem_csr_waddr !== e.ca || mem_csr_we !== e.ce) begin
                    errors++;
                    $display("FAIL wb_out got %h/%0d/%b %h/%h/%b exp %h/%0d/%b %h/%h/%b",
                             mem_reg_wdata, mem_reg_waddr, mem_reg_we,
                             mem_csr_wdata, mem_csr_waddr, mem_csr_we,
                             e.rw, e.ra, e.re, e.cw, e.ca, e.ce);
                end
`ifdef MEM_MISALIGN_CHECK_EN
                checks++;
                if (mem_misalign !== e.mis) begin
                    errors++;
                    $display("FAIL wb_misalign got %b exp %b",
                             mem_misalign, e.mis);
                end
`endif
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        dif.dcache_ready_i = 1'b0;
        present(0, 1, 0, 2'b10, 0, 32'h40, 0, 32'h1234, 0, 5'd1, 1);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (dif.mem_dcache_req_o !== 1'b0 || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_req got req=%b stall=%b exp 0/0",
                     dif.mem_dcache_req_o, mem_stall);
        end
        checks++;
        if (mem_valid !== 1'b0 || mem_reg_we !== 1'b0 ||
            mem_csr_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got v=%b we=%b cwe=%b exp 0",
                     mem_valid, mem_reg_we, mem_csr_we);
        end
        checks++;
        if (mem_reg_wdata !== 32'h0 || mem_reg_waddr !== 5'h0 ||
            mem_csr_wdata !== 32'h0 || mem_csr_waddr !== 12'h0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h exp 0",
                     mem_reg_wdata, mem_reg_waddr,
                     mem_csr_wdata, mem_csr_waddr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bubble();
    endtask

    task automatic test_alu();
        @(negedge clk);
        present(1, 0, 0, 2'b10, 0, 32'h0, 0, 32'h5, 0, 5'd3, 1);
        #1;
        checks++;
        if (dif.mem_dcache_req_o !== 1'b0 || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL alu_req got req=%b stall=%b exp 0/0",
                     dif.mem_dcache_req_o, mem_stall);
        end
        @(posedge clk);
        #2;
        checks++;
        if (mem_valid !== 1'b1 || mem_reg_wdata !== 32'h5 ||
            mem_reg_waddr !== 5'd3 || mem_reg_we !== 1'b1) begin
            errors++;
            $display("FAIL alu_wb got v=%b %h/%0d/%b exp 1 5/3/1",
                     mem_valid, mem_reg_wdata, mem_reg_waddr, mem_reg_we);
        end
    endtask

    task automatic test_load_byte();
        logic [31:0] want;
        for (int u = 0; u < 2; u++) begin
            @(negedge clk);
            dif.dcache_ready_i = 1'b1;
            present(1, 1, 0, 2'b00, u[0], 32'h103, 0, 32'hDEAD,
                    32'h80FF_FF00, 5'd7, 1);
            #1;
            checks++;
            if (dif.mem_dcache_req_o !== 1'b1 || mem_stall !== 1'b0 ||
                dif.mem_dcache_addr_o !== 32'h100 ||
                dif.mem_dcache_we_o !== 1'b0) begin
                errors++;
                $display("FAIL lb_req got req=%b st=%b a=%h we=%b exp 1/0/100/0",
                         dif.mem_dcache_req_o, mem_stall,
                         dif.mem_dcache_addr_o, dif.mem_dcache_we_o);
            end
            @(posedge clk);
            #2;
            want = (u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
            checks++;
            if (mem_valid !== 1'b1 || mem_reg_wdata !== want) begin
                errors++;
                $display("FAIL lb_data u=%0d got v=%b %h exp 1 %h",
                         u, mem_valid, mem_reg_wdata, want);
            end
        end
    endtask

    task automatic test_store_stall();
        int snap;
        @(negedge clk);
        snap = valid_cnt;
        dif.dcache_ready_i = 1'b0;
        present(1, 1, 1, 2'b01, 0, 32'h102, 32'h1234_ABCD, 32'h77, 0,
                5'd9, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mem_stall !== 1'b1 || dif.mem_dcache_req_o !== 1'b1 ||
                dif.mem_dcache_we_o !== 1'b1 ||
                dif.mem_dcache_addr_o !== 32'h100 ||
                dif.mem_dcache_wstrb_o !== 4'b1100 ||
                dif.mem_dcache_wdata_o !== 32'hABCD_ABCD) begin
                errors++;
                $display("FAIL sh_stall c=%0d got st=%b r=%b w=%b a=%h s=%b d=%h",
                         i, mem_stall, dif.mem_dcache_req_o,
                         dif.mem_dcache_we_o, dif.mem_dcache_addr_o,
                         dif.mem_dcache_wstrb_o, dif.mem_dcache_wdata_o);
            end
            @(negedge clk);
            if (i == 0)
                present(0, 0, 0, 2'b00, 1, 32'hFFFF_FFFD, 0, 32'h999, 0,
                        5'd30, 1);
        end
        dif.dcache_ready_i = 1'b1;
        #1;
        checks++;
        if (mem_stall !== 1'b0 || dif.mem_dcache_req_o !== 1'b1 ||
            dif.mem_dcache_addr_o !== 32'h100) begin
            errors++;
            $display("FAIL sh_done got st=%b r=%b a=%h exp 0/1/100",
                     mem_stall, dif.mem_dcache_req_o,
                     dif.mem_dcache_addr_o);
        end
        @(negedge clk);
        bubble();
        checks++;
        if (valid_cnt - snap != 1) begin
            errors++;
            $display("FAIL sh_pulses got %0d exp 1", valid_cnt - snap);
        end
    endtask

    task automatic test_wait_reset();
        @(negedge clk);
        dif.dcache_ready_i = 1'b0;
        present(0, 1, 0, 2'b10, 0, 32'h200, 0, 32'h55, 32'h1, 5'd5, 1);
        @(negedge clk);
        #1;
        checks++;
        if (mem_stall !== 1'b1) begin
            errors++;
            $display("FAIL wr_wait got st=%b exp 1", mem_stall);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dif.mem_dcache_req_o !== 1'b0 || mem_stall !== 1'b0 ||
            mem_valid !== 1'b0 || mem_reg_wdata !== 32'h0 ||
            mem_reg_we !== 1'b0) begin
            errors++;
            $display("FAIL wr_drop got r=%b st=%b v=%b d=%h we=%b exp 0",
                     dif.mem_dcache_req_o, mem_stall, mem_valid,
                     mem_reg_wdata, mem_reg_we);
        end
        @(negedge clk);
        rst_n = 1'b1;
        present(1, 0, 0, 2'b10, 0, 32'h0, 0, 32'h1111, 0, 5'd4, 1);
        #1;
        checks++;
        if (dif.mem_dcache_req_o !== 1'b0 || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL wr_idle got r=%b st=%b exp 0/0",
                     dif.mem_dcache_req_o, mem_stall);
        end
        @(posedge clk);
        #2;
        checks++;
        if (mem_valid !== 1'b1 || mem_reg_wdata !== 32'h1111) begin
            errors++;
            $display("FAIL wr_first got v=%b d=%h exp 1 1111",
                     mem_valid, mem_reg_wdata);
        end
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_CHECK_EN
        @(negedge clk);
        dif.dcache_ready_i = 1'b0;
        present(1, 1, 0, 2'b10, 0, 32'h101, 0, 32'h42, 32'hCAFE_BABE,
                5'd6, 1);
        #1;
        checks++;
        if (dif.mem_dcache_req_o !== 1'b0 || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL mis_req got r=%b st=%b exp 0/0",
                     dif.mem_dcache_req_o, mem_stall);
        end
        @(posedge clk);
        #2;
        checks++;
        if (mem_misalign !== 1'b1 || mem_reg_we !== 1'b0) begin
            errors++;
            $display("FAIL mis_flag got m=%b we=%b exp 1/0",
                     mem_misalign, mem_reg_we);
        end
        @(negedge clk);
        bubble();
        @(posedge clk);
        #2;
        checks++;
        if (mem_misalign !== 1'b0) begin
            errors++;
            $display("FAIL mis_pulse got %b exp 0", mem_misalign);
        end
`else
        @(negedge clk);
        dif.dcache_ready_i = 1'b1;
        present(1, 1, 0, 2'b10, 0, 32'h101, 0, 32'h42, 32'hCAFE_BABE,
                5'd6, 1);
        #1;
        checks++;
        if (dif.mem_dcache_req_o !== 1'b1 ||
            dif.mem_dcache_addr_o !== 32'h100) begin
            errors++;
            $display("FAIL lw_mis_req got r=%b a=%h exp 1/100",
                     dif.mem_dcache_req_o, dif.mem_dcache_addr_o);
        end
        @(posedge clk);
        #2;
        checks++;
        if (mem_reg_wdata !== 32'hCAFE_BABE) begin
            errors++;
            $display("FAIL lw_mis_data got %h exp cafebabe", mem_reg_wdata);
        end
        @(negedge clk);
        present(1, 1, 0, 2'b01, 0, 32'h103, 0, 32'h43, 32'h8001_1234,
                5'd8, 1);
        @(posedge clk);
        #2;
        checks++;
        if (mem_reg_wdata !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL lh_mis_data got %h exp ffff8001", mem_reg_wdata);
        end
        @(negedge clk);
        present(1, 1, 1, 2'b01, 0, 32'h103, 32'h0000_BEEF, 32'h44, 0,
                5'd10, 1);
        #1;
        checks++;
        if (dif.mem_dcache_wstrb_o !== 4'b1100 ||
            dif.mem_dcache_wdata_o !== 32'hBEEF_BEEF) begin
            errors++;
            $display("FAIL sh_mis got s=%b d=%h exp 1100 beefbeef",
                     dif.mem_dcache_wstrb_o, dif.mem_dcache_wdata_o);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic        mt;
        logic        rw;
        logic [1:0]  w;
        logic [31:0] a;
        logic [31:0] sd;
        logic [3:0]  s;
        logic [31:0] o;
        int          d;
        for (int n = 0; n < 30; n++) begin
            mt = ($urandom_range(0, 3) != 0);
            rw = $urandom_range(0, 1);
            w  = 2'($urandom_range(0, 3));
            a  = $urandom;
            if (w == 2'b01) a[0] = 1'b0;
            if (w[1]) a[1:0] = 2'b00;
            sd = $urandom;
            d  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            @(negedge clk);
            dif.dcache_ready_i = (d == 0);
            present(1, mt, rw, w, 1'($urandom_range(0, 1)), a, sd,
                    $urandom, $urandom, 5'($urandom), 1'($urandom));
            #1;
            model_store(w, a, sd, s, o);
            checks++;
            if (dif.mem_dcache_req_o !== mt ||
                mem_stall !== (mt && d != 0) ||
                (mt && (dif.mem_dcache_addr_o !== {a[31:2], 2'b00} ||
                        dif.mem_dcache_we_o !== rw)) ||
                (mt && rw && (dif.mem_dcache_wstrb_o !== s ||
                              dif.mem_dcache_wdata_o !== o))) begin
                errors++;
                $display("FAIL b2b_req n=%0d got r=%b st=%b a=%h s=%b d=%h exp %b %h %b %h",
                         n, dif.mem_dcache_req_o, mem_stall,
                         dif.mem_dcache_addr_o, dif.mem_dcache_wstrb_o,
                         dif.mem_dcache_wdata_o, mt, a, s, o);
            end
            if (mt) begin
                for (int j = 1; j <= d; j++) begin
                    @(negedge clk);
                    if (j == 1) ex_mem_addr = ~a;
                    if (j == d) dif.dcache_ready_i = 1'b1;
                    #1;
                    checks++;
                    if (dif.mem_dcache_req_o !== 1'b1 ||
                        dif.mem_dcache_addr_o !== {a[31:2], 2'b00} ||
                        mem_stall !== (j != d)) begin
                        errors++;
                        $display("FAIL b2b_hold n=%0d j=%0d got r=%b a=%h st=%b",
                                 n, j, dif.mem_dcache_req_o,
                                 dif.mem_dcache_addr_o, mem_stall);
                    end
                end
            end
        end
    endtask

    task automatic test_drain();
        @(negedge clk);
        bubble();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_byte();
        test_store_stall();
        test_wait_reset();
        test_misalign();
        test_back_to_back();
        test_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
